// File: rtl/pin_out_arbiter_pkg.sv
// Shared types and helpers for the pin output arbiter.
// Package pin_arb_pkg: FSM state type, index-width helper, reset pin value.
package pin_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam logic [7:0] IDLE_VALUE_DEFAULT = 8'h00;

    // Wide enough for burst lengths up to 15.
    localparam int BURST_CNT_W = 4;

    // Width needed for a requester index, never less than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pin_out_arbiter_if.sv
// Requester handshake and pin bus bundle for pin_out_arbiter.
// The master modport is the requester/pin-consumer side; slave is the arbiter.
interface pin_out_arbiter_if
    import pin_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) ();

    localparam int SRC_W = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         pin_out;
    logic [SRC_W-1:0]          pin_src;
    logic                      pin_active;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  pin_out,
        input  pin_src,
        input  pin_active
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output pin_out,
        output pin_src,
        output pin_active
    );

endinterface

// File: rtl/pin_out_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first valid requester at or after
// start_i (modulo NUM_REQ) wins, reported as a one-hot grant and an index.
module rr_pick
    import pin_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   start_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic found;
    int   pos;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = (int'(start_i) + k) % NUM_REQ;
            if (!found && valid_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/pin_out_arbiter.sv
// Round-robin arbiter sharing the dedicated output pin bus among requesters.
// Define PIN_ARB_BURST_EN to let an owner keep the grant for up to MAX_BURST beats.
module pin_out_arbiter
    import pin_arb_pkg::*;
#(
    parameter int                NUM_REQ    = 4,
    parameter int                DATA_W     = 8,
    parameter int                MAX_BURST  = 4,
    parameter logic [DATA_W-1:0] IDLE_VALUE = DATA_W'(IDLE_VALUE_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    pin_out_arbiter_if.slave   bus
);

    localparam int IDX_W = idx_w(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_cfg
        $error("pin_out_arbiter: NUM_REQ or MAX_BURST out of range");
    end

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [DATA_W-1:0]   pin_out_q, pin_out_d;
    logic [IDX_W-1:0]    pin_src_q, pin_src_d;
    logic                pin_active_q, pin_active_d;
`ifdef PIN_ARB_BURST_EN
    logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

    logic [IDX_W-1:0]    start;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    win_idx;
    logic [NUM_REQ-1:0]  ready;
    logic                retain;
    logic                xfer;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid_i (bus.req_valid),
        .start_i (start),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Grant never looks at req_data; reset masks it so ready drops asynchronously.
    always_comb begin
        start = (state_q == OWN) ? next_idx(owner_q) : ptr_q;
`ifdef PIN_ARB_BURST_EN
        retain = (state_q == OWN) && bus.req_valid[owner_q]
                 && (burst_cnt_q < BURST_CNT_W'(MAX_BURST));
`else
        retain = 1'b0;
`endif
        grant   = pick_grant;
        win_idx = pick_idx;
        if (retain) begin
            grant          = '0;
            grant[owner_q] = 1'b1;
            win_idx        = owner_q;
        end
        ready = (ena && rst_n) ? grant : '0;
        xfer  = |ready;
    end

    assign bus.req_ready = ready;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        pin_out_d    = pin_out_q;
        pin_src_d    = pin_src_q;
        pin_active_d = 1'b0;
`ifdef PIN_ARB_BURST_EN
        burst_cnt_d  = burst_cnt_q;
`endif
        if (ena) begin
            if (xfer) begin
                state_d      = OWN;
                owner_d      = win_idx;
                ptr_d        = next_idx(win_idx);
                pin_out_d    = bus.req_data[int'(win_idx)*DATA_W +: DATA_W];
                pin_src_d    = win_idx;
                pin_active_d = 1'b1;
`ifdef PIN_ARB_BURST_EN
                burst_cnt_d  = retain ? burst_cnt_q + BURST_CNT_W'(1) : BURST_CNT_W'(1);
`endif
            end else begin
                state_d = IDLE;
`ifdef PIN_ARB_BURST_EN
                burst_cnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            ptr_q        <= '0;
            pin_out_q    <= IDLE_VALUE;
            pin_src_q    <= '0;
            pin_active_q <= 1'b0;
`ifdef PIN_ARB_BURST_EN
            burst_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            ptr_q        <= ptr_d;
            pin_out_q    <= pin_out_d;
            pin_src_q    <= pin_src_d;
            pin_active_q <= pin_active_d;
`ifdef PIN_ARB_BURST_EN
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end

    assign bus.pin_out    = pin_out_q;
    assign bus.pin_src    = pin_src_q;
    assign bus.pin_active = pin_active_q;

endmodule

// File: tb/tb_pin_out_arbiter.sv
// Directed self-checking bench for pin_out_arbiter (4 requesters, 8-bit pins).
// Burst scenarios run only when PIN_ARB_BURST_EN is defined.
module tb_pin_out_arbiter;

    logic clk;
    logic rst_n;
    logic ena;
    int   vectors;
    int   miscompares;

    pin_out_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

    pin_out_arbiter #(
        .NUM_REQ    (4),
        .DATA_W     (8),
        .MAX_BURST  (4),
        .IDLE_VALUE (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (bus.pin_out !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_pin_out: got %h expected 00", bus.pin_out); end
        vectors++;
        if (bus.pin_active !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_active: got %b expected 0", bus.pin_active); end
        vectors++;
        if (bus.pin_src !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_src: got %0d expected 0", bus.pin_src); end
        vectors++;
        if (bus.req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0000", bus.req_ready); end
        tick();
        tick();
        vectors++;
        if (bus.pin_out !== 8'h00 || bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL reset_held: got pin_out %h ready %b expected 00 0000", bus.pin_out, bus.req_ready);
        end
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0000;
        bus.req_data  = {8'hC3, 8'hA5, 8'hC1, 8'hC0};
        rst_n = 1'b1;
        bus.req_valid = 4'b0100;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL single_ready: got %b expected 0100", bus.req_ready); end
        tick();
        vectors++;
        if (bus.pin_out !== 8'hA5) begin miscompares++; $display("[TB] FAIL single_pin_out: got %h expected a5", bus.pin_out); end
        vectors++;
        if (bus.pin_src !== 2'd2) begin miscompares++; $display("[TB] FAIL single_src: got %0d expected 2", bus.pin_src); end
        vectors++;
        if (bus.pin_active !== 1'b1) begin miscompares++; $display("[TB] FAIL single_active: got %b expected 1", bus.pin_active); end
        bus.req_valid = 4'b0000;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_ready_off: got %b expected 0000", bus.req_ready); end
        tick();
        vectors++;
        if (bus.pin_active !== 1'b0 || bus.pin_out !== 8'hA5 || bus.pin_src !== 2'd2) begin
            miscompares++;
            $display("[TB] FAIL single_idle_hold: got active %b pin_out %h src %0d expected 0 a5 2",
                     bus.pin_active, bus.pin_out, bus.pin_src);
        end
    endtask

    // Pointer sits at 3 after the single transfer from requester 2.
    task automatic test_round_robin();
        logic [1:0] exp_src;
        logic [3:0] exp_ready;
        bus.req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            exp_src   = 2'((3 + k) % 4);
            exp_ready = 4'b0001 << exp_src;
            #1;
            vectors++;
            if (bus.req_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL rr_ready[%0d]: got %b expected %b", k, bus.req_ready, exp_ready); end
            tick();
            vectors++;
            if (bus.pin_src !== exp_src || bus.pin_out !== (8'hC0 + 8'(exp_src)) || bus.pin_active !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL rr_beat[%0d]: got src %0d pin_out %h active %b expected %0d %h 1",
                         k, bus.pin_src, bus.pin_out, bus.pin_active, exp_src, 8'hC0 + 8'(exp_src));
            end
        end
    endtask

    task automatic test_ena_stall();
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (bus.req_ready !== 4'b0000) begin miscompares++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0000", k, bus.req_ready); end
            tick();
            vectors++;
            if (bus.pin_active !== 1'b0 || bus.pin_out !== 8'hC2 || bus.pin_src !== 2'd2) begin
                miscompares++;
                $display("[TB] FAIL stall_hold[%0d]: got active %b pin_out %h src %0d expected 0 c2 2",
                         k, bus.pin_active, bus.pin_out, bus.pin_src);
            end
        end
        ena = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b1000) begin miscompares++; $display("[TB] FAIL stall_resume_ready: got %b expected 1000", bus.req_ready); end
        tick();
        vectors++;
        if (bus.pin_src !== 2'd3 || bus.pin_out !== 8'hC3 || bus.pin_active !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL stall_resume_beat: got src %0d pin_out %h active %b expected 3 c3 1",
                     bus.pin_src, bus.pin_out, bus.pin_active);
        end
    endtask

    task automatic test_drop();
        bus.req_valid = 4'b0100;
        for (int b = 0; b < 2; b++) begin
            #1;
            vectors++;
            if (bus.req_ready !== 4'b0100) begin miscompares++; $display("[TB] FAIL drop_ready[%0d]: got %b expected 0100", b, bus.req_ready); end
            tick();
            vectors++;
            if (bus.pin_src !== 2'd2 || bus.pin_out !== 8'hC2) begin
                miscompares++;
                $display("[TB] FAIL drop_beat[%0d]: got src %0d pin_out %h expected 2 c2", b, bus.pin_src, bus.pin_out);
            end
        end
        bus.req_valid = 4'b0001;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL drop_wrap_ready: got %b expected 0001", bus.req_ready); end
        tick();
        vectors++;
        if (bus.pin_src !== 2'd0 || bus.pin_out !== 8'hC0 || bus.pin_active !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL drop_wrap_beat: got src %0d pin_out %h active %b expected 0 c0 1",
                     bus.pin_src, bus.pin_out, bus.pin_active);
        end
        bus.req_valid = 4'b0000;
        tick();
        vectors++;
        if (bus.pin_active !== 1'b0 || bus.pin_out !== 8'hC0 || bus.pin_src !== 2'd0) begin
            miscompares++;
            $display("[TB] FAIL drop_idle: got active %b pin_out %h src %0d expected 0 c0 0",
                     bus.pin_active, bus.pin_out, bus.pin_src);
        end
    endtask

    // Pointer is 1 here; a mid-cycle reset must clear outputs and pointer at once.
    task automatic test_mid_reset();
        bus.req_valid = 4'b1111;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0010) begin miscompares++; $display("[TB] FAIL mid_pre_ready: got %b expected 0010", bus.req_ready); end
        tick();
        vectors++;
        if (bus.pin_src !== 2'd1 || bus.pin_out !== 8'hC1) begin
            miscompares++;
            $display("[TB] FAIL mid_pre_beat: got src %0d pin_out %h expected 1 c1", bus.pin_src, bus.pin_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.pin_out !== 8'h00 || bus.pin_active !== 1'b0 || bus.pin_src !== 2'd0 || bus.req_ready !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got pin_out %h active %b src %0d ready %b expected 00 0 0 0000",
                     bus.pin_out, bus.pin_active, bus.pin_src, bus.req_ready);
        end
        tick();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL mid_post_ready: got %b expected 0001", bus.req_ready); end
        tick();
        vectors++;
        if (bus.pin_src !== 2'd0 || bus.pin_out !== 8'hC0 || bus.pin_active !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_post_beat: got src %0d pin_out %h active %b expected 0 c0 1",
                     bus.pin_src, bus.pin_out, bus.pin_active);
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask

`ifdef PIN_ARB_BURST_EN
    task automatic test_burst_rotate();
        logic [1:0] exp_seq [10] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd1, 2'd1};
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 10; k++) begin
            tick();
            vectors++;
            if (bus.pin_src !== exp_seq[k] || bus.pin_out !== (8'hC0 + 8'(exp_seq[k])) || bus.pin_active !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL burst_rot[%0d]: got src %0d pin_out %h active %b expected %0d %h 1",
                         k, bus.pin_src, bus.pin_out, bus.pin_active, exp_seq[k], 8'hC0 + 8'(exp_seq[k]));
            end
        end
    endtask

    task automatic test_burst_solo();
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            #1;
            vectors++;
            if (bus.req_ready !== 4'b0001) begin miscompares++; $display("[TB] FAIL solo_ready[%0d]: got %b expected 0001", k, bus.req_ready); end
            tick();
            vectors++;
            if (bus.pin_src !== 2'd0 || bus.pin_out !== 8'hC0 || bus.pin_active !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL solo_beat[%0d]: got src %0d pin_out %h active %b expected 0 c0 1",
                         k, bus.pin_src, bus.pin_out, bus.pin_active);
            end
        end
        bus.req_valid = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        vectors       = 0;
        miscompares   = 0;
        clk           = 1'b0;
        rst_n         = 1'b0;
        ena           = 1'b1;
        bus.req_valid = 4'b1111;
        bus.req_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        test_reset();
        test_single();
        test_round_robin();
        test_ena_stall();
        test_drop();
        test_mid_reset();
`ifdef PIN_ARB_BURST_EN
        test_burst_rotate();
        test_burst_solo();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
